// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Shared constants and types for the instruction fetch stage. The program RAM
//   and the decode stage use the same widths, so they live here in one place.
//
//   XLEN       instruction / data width
//   MEM_DEPTH  number of RAM words
//   PC_W       width of the word address held inside the fetch stage
//   RESET_PC   word address fetched first after reset
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    localparam int XLEN      = 32;
    localparam int MEM_DEPTH = 32;
    localparam int PC_W      = $clog2(MEM_DEPTH);

    typedef logic [PC_W-1:0] pc_t;

    localparam pc_t RESET_PC = '0;

    // One buffered instruction together with the word address it came from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        pc_t             pc;
    } fetch_entry_t;

    // Operating mode of the fetch stage, derived every cycle from occupancy and
    // the control inputs rather than held in a dedicated state register.
    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FULL  = 2'd2,
        FETCH_FLUSH = 2'd3
    } fetch_state_e;

    // Zero-extend an internal word address to the external bus width.
    function automatic logic [XLEN-1:0] zext_pc(input pc_t pc);
        return {{(XLEN-PC_W){1'b0}}, pc};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
//   Bus bundle between the fetch stage, the program RAM read port and decode.
//
//   pc_add       fetch -> RAM     read word address
//   ram_rdata    RAM   -> fetch   read data, valid the cycle after an issue
//   instr        fetch -> decode  instruction word
//   instr_pc     fetch -> decode  word address of instr, zero-extended
//   instr_valid  fetch -> decode  instr/instr_pc valid
//   instr_ready  decode -> fetch  decode accepts this cycle
//
//   master: the fetch stage side.  slave: the RAM/decode (environment) side.
// -----------------------------------------------------------------------------
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic [XLEN-1:0] pc_add;
    logic [XLEN-1:0] ram_rdata;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;

    modport master (
        output pc_add,
        input  ram_rdata,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  pc_add,
        output ram_rdata,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );

endinterface

// File: rtl/instr_fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
//   Two-entry {instr, pc} buffer: an output register that feeds decode and a
//   skid register that catches a word returning while the output register is
//   occupied and not being drained. Entries leave strictly in arrival order.
//
//   clk, rst_n   clock and asynchronous active-low reset
//   flush        drop both entries (data is kept, valid bits cleared)
//   push         push_entry is written this edge
//   push_entry   returning instruction and its word address
//   pop_ready    downstream ready; a pop happens when out_valid && pop_ready
//   out_valid    output register holds a valid entry
//   out_entry    output register contents
//   occ          number of valid entries (0..2)
//
//   The caller guarantees a push never arrives while both entries are full and
//   no pop is taking place.
// -----------------------------------------------------------------------------
module fetch_skid_buf
    import instr_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop_ready,
    output logic         out_valid,
    output fetch_entry_t out_entry,
    output logic [1:0]   occ
);

    fetch_entry_t out_q,  out_d;
    fetch_entry_t skid_q, skid_d;
    logic         out_valid_q,  out_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         pop;

    assign pop = out_valid_q && pop_ready;

    // Next-state for both entries. The skid entry is always older than any word
    // being pushed, so on a pop it moves forward and the new word takes its
    // place; without a skid entry a push goes straight to the output register.
    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop) begin
            if (skid_valid_q) begin
                out_d = skid_q;
                if (push) begin
                    skid_d = push_entry;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (push) begin
                out_d = push_entry;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (push) begin
            if (!out_valid_q) begin
                out_d       = push_entry;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = push_entry;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_entry = out_q;
    assign occ       = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage sitting directly after the program RAM. Holds the
//   program counter, issues one RAM read per cycle when there is room for the
//   returning word, tracks the single-cycle read latency and hands instructions
//   to decode over a valid/ready handshake through a two-entry buffer.
//
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   fetch_en        1 = issue new reads, 0 = stop issuing and let words drain
//   mem_busy        RAM write port active, no read may be issued
//   redirect_valid  branch/jump taken: flush and restart at redirect_pc
//   redirect_pc     new word address, only the low PC_W bits are used
//   bus             instr_fetch_if master: pc_add, ram_rdata, instr, instr_pc,
//                   instr_valid, instr_ready
//
//   pc_add is a plain register output, so decode's ready has no combinational
//   path to the RAM address.
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    input  logic            mem_busy,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    instr_fetch_if.master   bus
);

    pc_t          pc_q,          pc_d;
    logic         inflight_q,    inflight_d;
    pc_t          inflight_pc_q, inflight_pc_d;

    fetch_state_e state;
    logic         issue;
    logic         pop;
    logic [2:0]   occ_next;

    logic         buf_out_valid;
    fetch_entry_t buf_out_entry;
    logic [1:0]   buf_occ;
    logic         buf_push;
    fetch_entry_t buf_push_entry;

    // Only the low PC_W bits of the redirect target address the RAM.
    logic         redirect_pc_unused;
    assign redirect_pc_unused = ^redirect_pc[XLEN-1:PC_W];

    assign pop = buf_out_valid && bus.instr_ready;

    // Occupancy after this edge if nothing new is issued: buffered words plus
    // the word currently returning, minus the one decode takes. Issuing is only
    // allowed when this leaves a free slot for the word the new read returns.
    assign occ_next = {1'b0, buf_occ} + {2'b00, inflight_q} - {2'b00, pop};

    // Derived mode: a redirect wins over everything, a full pipeline blocks
    // issue, otherwise fetch runs when enabled and the RAM is not being written.
    always_comb begin
        state = FETCH_IDLE;
        if (redirect_valid) begin
            state = FETCH_FLUSH;
        end else if (occ_next >= 3'd2) begin
            state = FETCH_FULL;
        end else if (fetch_en && !mem_busy) begin
            state = FETCH_RUN;
        end
    end

    assign issue = (state == FETCH_RUN);

    // PC and read-tracking update. The in-flight flag only ever lasts one cycle
    // because the RAM always answers on the next edge; a redirect discards the
    // answer and restarts from the new target.
    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;

        if (state == FETCH_FLUSH) begin
            pc_d = redirect_pc[PC_W-1:0];
        end else if (issue) begin
            pc_d          = pc_q + 1'b1;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // The returning word is captured regardless of mem_busy: the RAM keeps its
    // read data stable while a write is in progress.
    assign buf_push             = inflight_q && !redirect_valid;
    assign buf_push_entry.instr = bus.ram_rdata;
    assign buf_push_entry.pc    = inflight_pc_q;

    fetch_skid_buf u_skid_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (buf_push),
        .push_entry (buf_push_entry),
        .pop_ready  (bus.instr_ready),
        .out_valid  (buf_out_valid),
        .out_entry  (buf_out_entry),
        .occ        (buf_occ)
    );

    assign bus.pc_add      = zext_pc(pc_q);
    assign bus.instr       = buf_out_entry.instr;
    assign bus.instr_pc    = zext_pc(buf_out_entry.pc);
    assign bus.instr_valid = buf_out_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. A behavioural RAM with a registered read
//   port (holding its data while mem_busy is high) sits on the bus. Expected
//   {instr, pc} pairs are queued when a fetch sequence is started and compared
//   by a monitor at every decode transfer; any transfer with nothing queued is
//   an error, which catches duplicated or extra words.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        mem_busy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] mem [MEM_DEPTH];
    exp_t        sb_q [$];
    int          errors;
    int          checks;
    logic [31:0] held_instr;
    logic [31:0] held_pc;
    logic [31:0] held_add;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .mem_busy       (mem_busy),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program RAM with a registered read port; the output holds while written.
    always @(posedge clk) begin
        if (!mem_busy) begin
            bus.ram_rdata <= mem[bus.pc_add[PC_W-1:0]];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fe, input logic busy, input logic rv,
                                 input logic [31:0] rpc, input logic rdy);
        fetch_en        = fe;
        mem_busy        = busy;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        bus.instr_ready = rdy;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushExpected(input int start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = 32'((start + i) % MEM_DEPTH);
            e.instr = mem[e.pc[PC_W-1:0]];
            sb_q.push_back(e);
        end
    endtask

    task automatic drainScoreboard(input string tag, input int limit);
        for (int i = 0; i < limit && sb_q.size() != 0; i++) begin
            waitCycles(1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput(tag, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    // Transfer monitor: inputs only change just after a rising edge, so values
    // seen at the falling edge are the ones the next rising edge acts on.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.instr_valid && bus.instr_ready) begin
            checkOutput("xfer_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checkOutput("instr", bus.instr, e.instr);
                checkOutput("instr_pc", bus.instr_pc, e.pc);
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
        end
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Reset values.
        waitCycles(2);
        checkOutput("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        checkOutput("rst_pc_add", bus.pc_add, 32'd0);
        checkOutput("rst_instr", bus.instr, 32'd0);
        checkOutput("rst_instr_pc", bus.instr_pc, 32'd0);

        // Stream from RESET_PC at full rate.
        rst_n = 1'b1;
        pushExpected(0, 4);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        waitCycles(1);
        checkOutput("t1_valid_after_issue", {31'd0, bus.instr_valid}, 32'd0);
        checkOutput("t1_pc_add_after_issue", bus.pc_add, 32'd1);
        waitCycles(1);
        checkOutput("t1_first_valid", {31'd0, bus.instr_valid}, 32'd1);
        waitCycles(4);
        checkOutput("t1_back_to_back", 32'(sb_q.size()), 32'd0);
        drainScoreboard("t1_drain", 4);

        // Decode stalls for 5 cycles mid-stream.
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd4, 1'b0);
        pushExpected(4, 8);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        waitCycles(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        waitCycles(1);
        held_instr = bus.instr;
        held_pc    = bus.instr_pc;
        held_add   = bus.pc_add;
        checkOutput("t2_stall_valid", {31'd0, bus.instr_valid}, 32'd1);
        checkOutput("t2_stall_pc_add", held_add, 32'd7);
        for (int i = 0; i < 3; i++) begin
            waitCycles(1);
            checkOutput("t2_hold_instr", bus.instr, held_instr);
            checkOutput("t2_hold_instr_pc", bus.instr_pc, held_pc);
            checkOutput("t2_hold_pc_add", bus.pc_add, held_add);
        end
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        drainScoreboard("t2_drain", 40);

        // Redirect while the buffer is filling and a read is in flight.
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd8, 1'b0);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        waitCycles(2);
        checkOutput("t3_pre_valid", {31'd0, bus.instr_valid}, 32'd1);
        checkOutput("t3_pre_pc_add", bus.pc_add, 32'd10);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'd20, 1'b0);
        pushExpected(20, 2);
        waitCycles(1);
        checkOutput("t3_flush_valid", {31'd0, bus.instr_valid}, 32'd0);
        checkOutput("t3_flush_pc_add", bus.pc_add, 32'd20);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        waitCycles(1);
        checkOutput("t3_edge1_valid", {31'd0, bus.instr_valid}, 32'd0);
        waitCycles(1);
        checkOutput("t3_edge2_valid", {31'd0, bus.instr_valid}, 32'd1);
        drainScoreboard("t3_drain", 20);

        // Address wrap, then a redirect whose upper bits must be ignored.
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd30, 1'b0);
        pushExpected(30, 4);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        drainScoreboard("t4_wrap_drain", 20);
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h25, 1'b0);
        waitCycles(1);
        checkOutput("t4_redirect_pc_add", bus.pc_add, 32'd5);
        pushExpected(5, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        drainScoreboard("t4_redirect_drain", 20);

        // RAM write port busy for 3 cycles during streaming.
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd10, 1'b0);
        pushExpected(10, 6);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        waitCycles(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("t5_busy_pc_add", bus.pc_add, 32'd12);
        for (int i = 0; i < 3; i++) begin
            waitCycles(1);
            checkOutput("t5_busy_hold_pc_add", bus.pc_add, 32'd12);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        drainScoreboard("t5_drain", 30);

        // Asynchronous reset in the middle of a stream.
        waitCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
        pushExpected(0, 10);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        waitCycles(3);
        checkOutput("t6_pre_valid", {31'd0, bus.instr_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_valid", {31'd0, bus.instr_valid}, 32'd0);
        checkOutput("t6_async_pc_add", bus.pc_add, 32'd0);
        checkOutput("t6_async_instr", bus.instr, 32'd0);
        checkOutput("t6_async_instr_pc", bus.instr_pc, 32'd0);
        sb_q.delete();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(2);
        checkOutput("t6_post_valid", {31'd0, bus.instr_valid}, 32'd0);
        checkOutput("t6_post_pc_add", bus.pc_add, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
